// File: rtl/sample_feeder.sv
// sample_feeder: buffers valid/ready samples in a small FIFO and presents them
// to the accelerator's left channel under a bundled-data 4-phase req/ack handshake.
module sample_feeder #(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int SETUP_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        in_ready,
  output logic [DATA_WIDTH-1:0]       data_in,
  output logic                        req_left,
  input  logic                        ack_left,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SCNT_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  DEPTH_C      = CNT_W'(FIFO_DEPTH);
  localparam logic [SCNT_W-1:0] SETUP_LAST_C = SCNT_W'(SETUP_CYCLES - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE_C    = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ONE_C    = CNT_W'(1'b1);
  localparam logic [SCNT_W-1:0] SCNT_ONE_C   = SCNT_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SETUP       = 2'd1,
    ST_WAIT_ACK_HI = 2'd2,
    ST_WAIT_ACK_LO = 2'd3
  } state_t;

  logic [DATA_WIDTH-1:0]  mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic [SYNC_STAGES-1:0] sync_r;
  state_t                 state_r;
  state_t                 state_next_s;
  logic [SCNT_W-1:0]      setup_cnt_r;
  logic [SCNT_W-1:0]      setup_cnt_next_s;
  logic [DATA_WIDTH-1:0]  data_in_r;
  logic [DATA_WIDTH-1:0]  data_next_s;
  logic                   req_r;
  logic                   req_next_s;
  logic                   busy_r;

  logic                   ack_s;
  logic                   full_s;
  logic                   empty_s;
  logic                   push_s;
  logic                   pop_s;
  logic [DATA_WIDTH-1:0]  head_s;

  // Only the last synchronizer stage may feed logic; earlier stages can be metastable.
  assign ack_s   = sync_r[SYNC_STAGES-1];
  assign full_s  = (count_r == DEPTH_C);
  assign empty_s = (count_r == {CNT_W{1'b0}});
  assign push_s  = in_valid && !full_s;
  assign head_s  = mem_r[rd_ptr_r];

  assign in_ready   = !full_s;
  assign data_in    = data_in_r;
  assign req_left   = req_r;
  assign fifo_count = count_r;
  assign busy       = busy_r;

  // ack_left synchronizer chain
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], ack_left};
    end
  end

  // FIFO storage, no reset needed since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Handshake FSM next-state and output decode
  always_comb begin
    state_next_s     = state_r;
    setup_cnt_next_s = setup_cnt_r;
    data_next_s      = data_in_r;
    req_next_s       = req_r;
    pop_s            = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // ack must be low before a new request so the previous cycle is fully closed
        if (!empty_s && !ack_s) begin
          data_next_s      = head_s;
          setup_cnt_next_s = {SCNT_W{1'b0}};
          state_next_s     = ST_SETUP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (setup_cnt_r == SETUP_LAST_C) begin
          req_next_s   = 1'b1;
          state_next_s = ST_WAIT_ACK_HI;
        end else begin
          setup_cnt_next_s = setup_cnt_r + SCNT_ONE_C;
        end
      end
      ST_WAIT_ACK_HI: begin
        if (ack_s) begin
          req_next_s   = 1'b0;
          pop_s        = 1'b1;
          state_next_s = ST_WAIT_ACK_LO;
        end else begin
          req_next_s = 1'b1;
        end
      end
      ST_WAIT_ACK_LO: begin
        if (!ack_s) begin
          state_next_s = ST_IDLE;
        end else begin
          req_next_s = 1'b0;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        req_next_s   = 1'b0;
      end
    endcase
  end

  // Handshake FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      setup_cnt_r <= {SCNT_W{1'b0}};
      data_in_r   <= {DATA_WIDTH{1'b0}};
      req_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      setup_cnt_r <= setup_cnt_next_s;
      data_in_r   <= data_next_s;
      req_r       <= req_next_s;
      busy_r      <= (state_next_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_sample_feeder.sv
// Scoreboard bench for sample_feeder: accepted pushes are queued as expectations,
// each req_left rising edge captures a delivered sample for in-order comparison.
module tb_sample_feeder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] data_in;
  logic       req_left;
  logic       ack_left;
  logic [2:0] fifo_count;
  logic       busy;

  bit         resp_auto;
  int         resp_delay;
  logic       ack_auto;
  logic       ack_manual;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  int n_checks;
  int n_fail;

  assign ack_left = resp_auto ? ack_auto : ack_manual;

  sample_feeder #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(4),
    .SYNC_STAGES(2),
    .SETUP_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .data_in(data_in),
    .req_left(req_left),
    .ack_left(ack_left),
    .fifo_count(fifo_count),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Delivery monitor: data_in captured on each rising edge of req_left
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (req_left === 1'b1 && prev_req !== 1'b1) got_q.push_back(data_in);
      prev_req = req_left;
    end
  end

  // Automatic responder: ack follows req after resp_delay cycles
  initial begin
    int cnt;
    cnt = 0;
    ack_auto = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (resp_auto && (req_left !== ack_auto)) begin
        cnt++;
        if (cnt > resp_delay) begin
          ack_auto = req_left;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic push_sample(input logic [7:0] d, input int budget, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    for (int i = 0; i < budget && !ok; i++) begin
      if (in_ready === 1'b1) begin
        exp_q.push_back(d);
        ok = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (req_left !== 1'b0 || data_in !== 8'h00 || fifo_count !== 3'd0 ||
          in_ready !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: req=%b data_in=%h count=%0d ready=%b busy=%b, expected 0 00 0 1 0",
                 i, req_left, data_in, fifo_count, in_ready, busy);
      end
    end
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    n_checks++;
    if (fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_no_write: count=%0d, expected 0", fifo_count);
    end
  endtask

  task automatic test_single();
    bit ok;
    logic [7:0] prev1, prev2;
    logic [2:0] req_seq;
    logic [7:0] e, g;
    resp_auto = 1'b1;
    resp_delay = 3;
    push_sample(8'h5A, 4, ok);
    n_checks++;
    if (!ok || fifo_count !== 3'd1) begin
      n_fail++;
      $display("FAIL single_count_one: accepted=%b count=%0d, expected 1 1", ok, fifo_count);
    end
    prev1 = data_in;
    prev2 = data_in;
    for (int k = 0; k < 20; k++) begin
      step();
      if (req_left === 1'b1) break;
      prev2 = prev1;
      prev1 = data_in;
    end
    n_checks++;
    if (req_left !== 1'b1 || prev1 !== 8'h5A || prev2 !== 8'h00 || data_in !== 8'h5A) begin
      n_fail++;
      $display("FAIL single_setup_lead: req=%b data@-2=%h data@-1=%h data@0=%h, expected 1 00 5a 5a",
               req_left, prev2, prev1, data_in);
    end
    for (int k = 0; k < 10 && ack_left !== 1'b1; k++) step();
    // the next edge is the first to capture ack high; req must drop two edges after it
    step(); req_seq[2] = req_left;
    step(); req_seq[1] = req_left;
    step(); req_seq[0] = req_left;
    n_checks++;
    if (req_seq !== 3'b110 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_req_fall: req seq=%b count=%0d, expected 110 0", req_seq, fifo_count);
    end
    for (int k = 0; k < 30 && busy !== 1'b0; k++) step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_idle: busy=%b, expected 0", busy);
    end
    n_checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL single_delivery: got %0d deliveries, expected 1", got_q.size());
    end else begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      if (g !== e) begin
        n_fail++;
        $display("FAIL single_delivery: data=%h, expected %h", g, e);
      end
    end
  endtask

  task automatic test_fill();
    bit ok;
    int n_ok;
    logic [7:0] e, g;
    resp_auto = 1'b0;
    ack_manual = 1'b0;
    n_ok = 0;
    for (int i = 1; i <= 4; i++) begin
      push_sample(8'(i), 6, ok);
      if (ok) n_ok++;
    end
    n_checks++;
    if (n_ok != 4) begin
      n_fail++;
      $display("FAIL fill_accept: accepted %0d, expected 4", n_ok);
    end
    push_sample(8'h05, 8, ok);
    n_checks++;
    if (ok) begin
      n_fail++;
      $display("FAIL fill_reject: 0x05 accepted, expected rejected");
    end
    n_checks++;
    if (fifo_count !== 3'd4 || in_ready !== 1'b0 || req_left !== 1'b1 || got_q.size() != 1) begin
      n_fail++;
      $display("FAIL fill_backpressure: count=%0d ready=%b req=%b requests=%0d, expected 4 0 1 1",
               fifo_count, in_ready, req_left, got_q.size());
    end
    resp_auto = 1'b1;
    resp_delay = 2;
    for (int k = 0; k < 200 && !(got_q.size() >= 4 && busy === 1'b0); k++) step();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fill_order[%0d]: no delivery, expected %0d more", i, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        g = got_q.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL fill_order[%0d]: data=%h, expected %h", i, g, e);
        end
      end
    end
  endtask

  task automatic test_push_pop();
    bit ok, ok_a, ok_b;
    logic [7:0] e, g;
    resp_auto = 1'b0;
    ack_manual = 1'b0;
    push_sample(8'hA1, 6, ok_a);
    push_sample(8'hA2, 6, ok_b);
    for (int k = 0; k < 10 && req_left !== 1'b1; k++) step();
    n_checks++;
    if (!(ok_a && ok_b) || fifo_count !== 3'd2 || req_left !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_setup: count=%0d req=%b, expected 2 1", fifo_count, req_left);
    end
    ack_manual = 1'b1;
    step();
    step();
    // the pop lands on the next edge; push on that same edge
    push_sample(8'h33, 1, ok);
    n_checks++;
    if (!ok || fifo_count !== 3'd2 || req_left !== 1'b0) begin
      n_fail++;
      $display("FAIL pp_count_hold: accepted=%b count=%0d req=%b, expected 1 2 0", ok, fifo_count, req_left);
    end
    resp_auto = 1'b1;
    resp_delay = 1;
    for (int k = 0; k < 200 && !(got_q.size() >= 3 && busy === 1'b0); k++) step();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pp_order[%0d]: no delivery, expected %0d more", i, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        g = got_q.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL pp_order[%0d]: data=%h, expected %h", i, g, e);
        end
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0] e, g;
    resp_auto = 1'b1;
    resp_delay = 1;
    for (int i = 0; i < 10; i++) push_sample(8'h10 + 8'(i), 40, ok);
    for (int k = 0; k < 400 && !(got_q.size() >= 10 && busy === 1'b0); k++) step();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wrap_order[%0d]: no delivery, expected %0d more", i, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        g = got_q.pop_front();
        if (g !== (8'h10 + 8'(i)) || g !== e) begin
          n_fail++;
          $display("FAIL wrap_order[%0d]: data=%h, expected %h", i, g, 8'h10 + 8'(i));
        end
      end
    end
    for (int k = 0; k < 20; k++) step();
    n_checks++;
    if (got_q.size() != 0 || exp_q.size() != 0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap_no_dup: extra deliveries=%0d missing=%0d count=%0d, expected 0 0 0",
               got_q.size(), exp_q.size(), fifo_count);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] e, g;
    resp_auto = 1'b0;
    ack_manual = 1'b0;
    push_sample(8'hB1, 6, ok);
    push_sample(8'hB2, 6, ok);
    push_sample(8'hB3, 6, ok);
    for (int k = 0; k < 10 && req_left !== 1'b1; k++) step();
    n_checks++;
    if (fifo_count !== 3'd3 || req_left !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_setup: count=%0d req=%b busy=%b, expected 3 1 1", fifo_count, req_left, busy);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (req_left !== 1'b0 || fifo_count !== 3'd0 || data_in !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_reset: req=%b count=%0d data_in=%h busy=%b ready=%b, expected 0 0 00 0 1",
               req_left, fifo_count, data_in, busy, in_ready);
    end
    rst = 1'b1;
    exp_q.delete();
    got_q.delete();
    resp_auto = 1'b1;
    resp_delay = 2;
    push_sample(8'h77, 6, ok);
    for (int k = 0; k < 60 && !(got_q.size() >= 1 && busy === 1'b0); k++) step();
    n_checks++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL rmid_first: no delivery, expected 77");
    end else begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      if (g !== 8'h77 || g !== e) begin
        n_fail++;
        $display("FAIL rmid_first: data=%h, expected 77", g);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    resp_auto = 1'b0;
    resp_delay = 1;
    ack_manual = 1'b0;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    test_reset();
    test_single();
    test_fill();
    test_push_pop();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
